div_5_bit_seq: RTL and testbench

DIV_5_BIT_SEQ -- requirements
Module: div_5_bit_seq

---
 rtl/div_5_bit_seq_pkg.sv | 13 +
 rtl/div_5_bit_seq_div_step.sv | 20 ++
 rtl/div_5_bit_seq.sv | 118 +++++++++++
 tb/tb_div_5_bit_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/div_5_bit_seq_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_5_bit_seq_pkg;

    localparam int WIDTH  = 5;
    localparam int STEP_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_5_bit_seq_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial remainder.
module div_step
    import div_5_bit_seq_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W:0]   i_prem,
    input  logic [W-1:0] i_divisor,
    output logic [W:0]   o_rem,
    output logic         o_qbit
);

    logic [W+1:0] w_diff;

    // Extra top bit is the borrow: set means the trial subtraction went negative.
    assign w_diff = {1'b0, i_prem} - {2'b00, i_divisor};
    assign o_qbit = ~w_diff[W+1];
    assign o_rem  = o_qbit ? w_diff[W:0] : i_prem;

endmodule

// File: rtl/div_5_bit_seq.sv
// Sequential unsigned divider: one quotient bit per cycle, MSB first.
//   state | meaning
//   IDLE  | waiting for start; results held
//   RUN   | WIDTH restoring steps
//   DONE  | write results; done pulses in the following cycle
module div_5_bit_seq #(
    parameter int WIDTH = div_5_bit_seq_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    import div_5_bit_seq_pkg::*;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [STEP_W-1:0]  r_step;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvsr;
    logic [WIDTH:0]     r_prem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH:0]     w_prem_in;
    logic [WIDTH:0]     w_prem_out;
    logic               w_qbit;

    assign w_prem_in = (r_prem << 1) | {{WIDTH{1'b0}}, r_dvd[WIDTH-1]};

    div_step #(.W(WIDTH)) u_div_step (
        .i_prem    (w_prem_in),
        .i_divisor (r_dvsr),
        .o_rem     (w_prem_out),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (B == '0) ? DONE : RUN;
            RUN:     if (r_step == LAST_STEP) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == RUN);
        done     = r_done;
        div_zero = r_div_zero;
        Quot     = r_quot;
        Rem      = r_rem;
    end

    // The dividend register shifts out dividend bits and shifts in quotient bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step     <= '0;
            r_dvd      <= '0;
            r_dvsr     <= '0;
            r_prem     <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvd      <= A;
                        r_dvsr     <= B;
                        r_prem     <= '0;
                        r_step     <= '0;
                        r_div_zero <= 1'b0;
                    end
                end
                RUN: begin
                    r_prem <= w_prem_out;
                    r_dvd  <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_step <= (r_step == LAST_STEP) ? '0 : r_step + 1'b1;
                end
                DONE: begin
                    r_done <= 1'b1;
                    if (r_dvsr == '0) begin
                        r_quot     <= '1;
                        r_rem      <= r_dvd;
                        r_div_zero <= 1'b1;
                    end else begin
                        r_quot <= r_dvd;
                        r_rem  <= r_prem[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_5_bit_seq.sv
// Scoreboard bench for div_5_bit_seq: driver queues expected results, monitor checks on done.
module tb_div_5_bit_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] A;
    logic [4:0] B;
    logic [4:0] Quot;
    logic [4:0] Rem;
    logic       busy;
    logic       done;
    logic       div_zero;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] q;
        logic [4:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    div_5_bit_seq #(.WIDTH(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .Quot     (Quot),
        .Rem      (Rem),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns 1ns after the accepting posedge.
    task automatic issue(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] q, input logic [4:0] r, input bit push);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.q  = q;
        e.r  = r;
        e.dz = (b == 5'd0);
        A     = a;
        B     = b;
        start = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = 5'($urandom);
        B     = 5'($urandom);
    endtask

    task automatic wait_done(input int exp_lat, input int exp_busy, input string tag);
        int cyc  = 0;
        int nb   = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (busy) nb++;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, cyc, exp_lat);
            check({tag, "_busy_cycles"}, nb, exp_busy);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("done_without_request", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("quot", 32'(Quot), 32'(e.q));
                check("rem", 32'(Rem), 32'(e.r));
                check("div_zero", 32'(div_zero), 32'(e.dz));
                check("busy_at_done", 32'(busy), 32'd0);
                if (e.b != 5'd0) begin
                    check("invariant_a_eq_qb_plus_r", 32'(Quot) * 32'(e.b) + 32'(Rem), 32'(e.a));
                    check("invariant_rem_lt_b", 32'(Rem < e.b), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst   = 1'b1;
        start = 1'b0;
        A     = 5'd0;
        B     = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_quot", 32'(Quot), 32'd0);
        check("reset_rem", 32'(Rem), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_div_zero", 32'(div_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(5'd23, 5'd4, 5'd5, 5'd3, 1'b1);
        wait_done(7, 5, "d23_4");
        issue(5'd31, 5'd1, 5'd31, 5'd0, 1'b1);
        wait_done(7, 5, "d31_1");
        issue(5'd3, 5'd9, 5'd0, 5'd3, 1'b1);
        wait_done(7, 5, "d3_9");

        repeat (3) @(negedge clk);
        check("hold_quot", 32'(Quot), 32'd0);
        check("hold_rem", 32'(Rem), 32'd3);

        issue(5'd7, 5'd0, 5'd31, 5'd7, 1'b1);
        wait_done(2, 0, "d7_0");
        repeat (3) @(negedge clk);
        check("dz_hold_flag", 32'(div_zero), 32'd1);
        check("dz_hold_quot", 32'(Quot), 32'd31);
        check("dz_hold_rem", 32'(Rem), 32'd7);

        // Start pulsed mid-run with new operands must be ignored.
        issue(5'd20, 5'd6, 5'd3, 5'd2, 1'b1);
        @(negedge clk);
        check("dz_cleared_on_accept", 32'(div_zero), 32'd0);
        A     = 5'd9;
        B     = 5'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6, 4, "d20_6_ignore");
        repeat (10) @(negedge clk);

        // Reset during the third RUN cycle aborts with no done.
        issue(5'd25, 5'd4, 5'd6, 5'd1, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_quot", 32'(Quot), 32'd0);
        check("abort_rem", 32'(Rem), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_div_zero", 32'(div_zero), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'd0);
        issue(5'd10, 5'd3, 5'd3, 5'd1, 1'b1);
        wait_done(7, 5, "d10_3");

        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                int q;
                int r;
                q = (b == 0) ? 31 : a / b;
                r = (b == 0) ? a : a % b;
                issue(5'(a), 5'(b), 5'(q), 5'(r), 1'b1);
                wait_done((b == 0) ? 2 : 7, (b == 0) ? 0 : 5, "exh");
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
